// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32 decode types, opcodes, funct7 codes and the extended control word.
package rv32i_types;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } muldiv_ops_e;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} decode_state_t;
  // alu_op is {alt, funct3}; alt selects sub/sra
  typedef struct packed {
    logic [3:0]  alu_op;
    logic        a_pc;
    logic        a_zero;
    logic        b_imm;
    logic        load_regfile;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_width;
    logic        branch;
    logic        jump;
    logic        muldiv_en;
    muldiv_ops_e muldiv_op;
    logic        illegal;
  } ctrl_t;
endpackage

// File: rtl/decode_core.sv
// decode_core: combinational RV32I(+M) decoder from instruction word to control, register indices and immediate.
module decode_core import rv32i_types::*; #(
  parameter bit ENABLE_M = 1'b0,
  parameter int XLEN     = 32
) (
  input  logic [31:0]     instr,
  output ctrl_t           ctrl,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       bad;
  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rd  = instr[11:7];
  always_comb begin
    ctrl = '0;
    imm  = '0;
    bad  = 1'b0;
    case (opc)
      OPC_LUI: begin
        ctrl.a_zero = 1'b1; ctrl.b_imm = 1'b1; ctrl.load_regfile = 1'b1;
        imm = XLEN'($signed({instr[31:12], 12'h000}));
      end
      OPC_AUIPC: begin
        ctrl.a_pc = 1'b1; ctrl.b_imm = 1'b1; ctrl.load_regfile = 1'b1;
        imm = XLEN'($signed({instr[31:12], 12'h000}));
      end
      OPC_JAL: begin
        ctrl.jump = 1'b1; ctrl.a_pc = 1'b1; ctrl.load_regfile = 1'b1;
        imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      OPC_JALR: begin
        ctrl.jump = 1'b1; ctrl.b_imm = 1'b1; ctrl.load_regfile = 1'b1;
        imm = XLEN'($signed(instr[31:20]));
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1; ctrl.alu_op = {1'b0, f3};
        imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      OPC_LOAD: begin
        ctrl.mem_read = 1'b1; ctrl.b_imm = 1'b1; ctrl.load_regfile = 1'b1; ctrl.mem_width = f3;
        imm = XLEN'($signed(instr[31:20]));
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1; ctrl.b_imm = 1'b1; ctrl.mem_width = f3;
        imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      OPC_OP_IMM: begin
        bad = f3 == 3'b001 ? f7 != F7_BASE : f3 == 3'b101 ? (f7 != F7_BASE && f7 != F7_ALT) : 1'b0;
        ctrl.b_imm = 1'b1; ctrl.load_regfile = 1'b1;
        ctrl.alu_op = {f3 == 3'b101 && instr[30], f3};
        imm = XLEN'($signed(instr[31:20]));
      end
      OPC_OP: begin
        if (ENABLE_M && f7 == F7_MULDIV) begin
          ctrl.muldiv_en = 1'b1; ctrl.muldiv_op = muldiv_ops_e'(f3); ctrl.load_regfile = 1'b1;
        end else begin
          bad = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
          ctrl.load_regfile = 1'b1; ctrl.alu_op = {instr[30], f3};
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ctrl = '0;
      ctrl.illegal = 1'b1;
      imm = '0;
    end
    if (rd == 5'd0) ctrl.load_regfile = 1'b0;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode with a main + skid buffer so in_ready depends only on local state.
module decode_stage import rv32i_types::*; #(
  parameter bit ENABLE_M = 1'b0,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm
);
  typedef struct packed {
    ctrl_t           ctrl;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] imm, pc;
  } entry_t;
  entry_t          dec, main_q, skid_q;
  ctrl_t           d_ctrl;
  logic [4:0]      d_rs1, d_rs2, d_rd;
  logic [XLEN-1:0] d_imm;
  decode_state_t   state, nxt;
  logic            acc, ret, ld_main, ld_skid;
  decode_core #(.ENABLE_M(ENABLE_M), .XLEN(XLEN)) u_core (
    .instr(instr), .ctrl(d_ctrl), .rs1(d_rs1), .rs2(d_rs2), .rd(d_rd), .imm(d_imm)
  );
  assign dec       = {d_ctrl, d_rs1, d_rs2, d_rd, d_imm, in_pc};
  assign in_ready  = state != TWO;
  assign out_valid = state != EMPTY;
  assign acc       = in_valid && in_ready;
  assign ret       = out_valid && out_ready;
  assign {ctrl, rs1, rs2, rd, imm, out_pc} = main_q;
  always_comb begin
    nxt = flush ? EMPTY
        : state == EMPTY ? (acc ? ONE : EMPTY)
        : state == ONE ? (acc && !ret ? TWO : !acc && ret ? EMPTY : ONE)
        : (ret ? ONE : TWO);
    ld_main = state == TWO ? ret : acc && (state == EMPTY || ret);
    ld_skid = state == ONE && acc && !ret;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= nxt;
      if (ld_main) main_q <= state == TWO ? skid_q : dec;
      if (ld_skid) skid_q <= dec;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: vector table, directed buffering sequences and random traffic against a queue model.
module tb_decode_stage;
  import rv32i_types::*;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0, in_pc = '0;
  logic in_ready, out_valid, in_ready0, out_valid0;
  ctrl_t ctrl, ctrl0;
  logic [31:0] out_pc, imm, out_pc0, imm0;
  logic [4:0] rs1, rs2, rd, rs1_0, rs2_0, rd0;
  int checks = 0, errors = 0;

  typedef struct packed { ctrl_t c; logic [31:0] imm; } dec_t;
  typedef struct packed { logic [31:0] ins; logic [31:0] pc; } ent_t;
  typedef struct {
    logic [31:0] ins; logic [31:0] imm; logic [4:0] rd;
    logic lr_m, ill_m, md_m; logic [2:0] mdop; logic lr_0, ill_0;
  } vec_t;
  ent_t q[$];

  decode_stage #(.ENABLE_M(1'b1), .XLEN(32)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .ctrl(ctrl), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm));
  decode_stage #(.ENABLE_M(1'b0), .XLEN(32)) dut_0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .instr(instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid0), .out_ready(out_ready), .ctrl(ctrl0), .out_pc(out_pc0),
    .rs1(rs1_0), .rs2(rs2_0), .rd(rd0), .imm(imm0));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sx(input int v, input int bits);
    return 32'(v >= (1 << (bits - 1)) ? v - (1 << bits) : v);
  endfunction

  // Reference decoder: instruction classes mapped straight to their control fields
  function automatic dec_t mdl(input logic [31:0] i, input bit en_m);
    dec_t d;
    bit ok;
    logic [2:0] f3;
    logic [6:0] f7;
    d = '0; ok = 1; f3 = i[14:12]; f7 = i[31:25];
    if (i[6:0] == 7'h37 || i[6:0] == 7'h17) begin
      d.c.a_zero = i[6:0] == 7'h37; d.c.a_pc = i[6:0] == 7'h17;
      d.c.b_imm = 1; d.c.load_regfile = 1; d.imm = {i[31:12], 12'h000};
    end else if (i[6:0] == 7'h6f) begin
      d.c.jump = 1; d.c.a_pc = 1; d.c.load_regfile = 1;
      d.imm = sx(int'(i[31]) * (1 << 20) + int'(i[19:12]) * (1 << 12) + int'(i[20]) * (1 << 11) + int'(i[30:21]) * 2, 21);
    end else if (i[6:0] == 7'h67 || i[6:0] == 7'h03) begin
      d.c.jump = i[6:0] == 7'h67; d.c.mem_read = i[6:0] == 7'h03;
      d.c.mem_width = i[6:0] == 7'h03 ? f3 : 3'd0;
      d.c.b_imm = 1; d.c.load_regfile = 1; d.imm = sx(int'(i[31:20]), 12);
    end else if (i[6:0] == 7'h63) begin
      d.c.branch = 1; d.c.alu_op = {1'b0, f3};
      d.imm = sx(int'(i[31]) * (1 << 12) + int'(i[7]) * (1 << 11) + int'(i[30:25]) * 32 + int'(i[11:8]) * 2, 13);
    end else if (i[6:0] == 7'h23) begin
      d.c.mem_write = 1; d.c.b_imm = 1; d.c.mem_width = f3;
      d.imm = sx(int'(i[31:25]) * 32 + int'(i[11:7]), 12);
    end else if (i[6:0] == 7'h13) begin
      if (f3 == 3'd1) ok = f7 == 0;
      if (f3 == 3'd5) ok = f7 == 0 || f7 == 7'h20;
      d.c.b_imm = 1; d.c.load_regfile = 1; d.c.alu_op = {f3 == 3'd5 && f7 == 7'h20, f3};
      d.imm = sx(int'(i[31:20]), 12);
    end else if (i[6:0] == 7'h33 && f7 == 7'h01) begin
      ok = en_m; d.c.muldiv_en = 1; d.c.muldiv_op = muldiv_ops_e'(f3); d.c.load_regfile = 1;
    end else if (i[6:0] == 7'h33) begin
      ok = f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      d.c.load_regfile = 1; d.c.alu_op = {f7 == 7'h20, f3};
    end else ok = 0;
    if (!ok) begin
      d = '0; d.c.illegal = 1;
    end
    if (i[11:7] == 0) d.c.load_regfile = 0;
    return d;
  endfunction

  task automatic check_model();
    dec_t e, e0;
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("out_valid_m0", 64'(out_valid0), 64'(q.size() != 0));
    if (q.size() != 0) begin
      e = mdl(q[0].ins, 1'b1);
      e0 = mdl(q[0].ins, 1'b0);
      chk("out_pc", 64'(out_pc), 64'(q[0].pc));
      chk("ctrl", 64'(ctrl), 64'(e.c));
      chk("imm", 64'(imm), 64'(e.imm));
      chk("rd", 64'(rd), 64'(q[0].ins[11:7]));
      chk("rs1", 64'(rs1), 64'(q[0].ins[19:15]));
      chk("rs2", 64'(rs2), 64'(q[0].ins[24:20]));
      chk("ctrl_m0", 64'(ctrl0), 64'(e0.c));
      chk("imm_m0", 64'(imm0), 64'(e0.imm));
    end
  endtask

  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bit acc, ret;
    @(negedge clk);
    in_valid = iv; instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1 check_model();
    acc = iv && q.size() < 2;
    ret = ordy && q.size() != 0;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (ret) void'(q.pop_front());
      if (acc) q.push_back('{ins, pc});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; out_ready = 0; flush = 0;
    #2 rst = 0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_ctrl", 64'(ctrl), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_regs", 64'({rs1, rs2, rd}), 64'd0);
    chk("rst_imm", 64'(imm), 64'd0);
    chk("rst_ctrl_m0", 64'(ctrl0), 64'd0);
    q.delete();
    @(negedge clk) rst = 1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops [10];
    logic [31:0] w;
    int k;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h33};
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 10) w[6:0] = ops[k];
    if (w[6:0] == 7'h33 || (w[6:0] == 7'h13 && w[13:12] == 2'b01))
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    return w;
  endfunction

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{32'h00500093, 32'h00000005, 5'd1,  1, 0, 0, 3'd0, 1, 0};
    tbl[1]  = '{32'h022081B3, 32'h00000000, 5'd3,  1, 0, 1, 3'd0, 0, 1};
    tbl[2]  = '{32'h00100013, 32'h00000001, 5'd0,  0, 0, 0, 3'd0, 0, 0};
    tbl[3]  = '{32'h123452B7, 32'h12345000, 5'd5,  1, 0, 0, 3'd0, 1, 0};
    tbl[4]  = '{32'hFE20AE23, 32'hFFFFFFFC, 5'd28, 0, 0, 0, 3'd0, 0, 0};
    tbl[5]  = '{32'hFE000CE3, 32'hFFFFFFF8, 5'd25, 0, 0, 0, 3'd0, 0, 0};
    tbl[6]  = '{32'h001000EF, 32'h00000800, 5'd1,  1, 0, 0, 3'd0, 1, 0};
    tbl[7]  = '{32'hFFFFFFFF, 32'h00000000, 5'd31, 0, 1, 0, 3'd0, 0, 1};
    tbl[8]  = '{32'h40109093, 32'h00000000, 5'd1,  0, 1, 0, 3'd0, 0, 1};
    tbl[9]  = '{32'h40315113, 32'h00000403, 5'd2,  1, 0, 0, 3'd0, 1, 0};
    tbl[10] = '{32'h402081B3, 32'h00000000, 5'd3,  1, 0, 0, 3'd0, 1, 0};
    tbl[11] = '{32'h042081B3, 32'h00000000, 5'd3,  0, 1, 0, 3'd0, 0, 1};
    tbl[12] = '{32'hFFF00093, 32'hFFFFFFFF, 5'd1,  1, 0, 0, 3'd0, 1, 0};
    tbl[13] = '{32'h0220B233, 32'h00000000, 5'd4,  1, 0, 1, 3'd3, 0, 1};

    do_reset();
    foreach (tbl[k]) begin
      cycle(1, tbl[k].ins, 32'(k * 4), 1, 0);
      #1;
      chk($sformatf("v%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_rd", k), 64'(rd), 64'(tbl[k].rd));
      chk($sformatf("v%0d_imm", k), 64'(imm), 64'(tbl[k].imm));
      chk($sformatf("v%0d_lr", k), 64'(ctrl.load_regfile), 64'(tbl[k].lr_m));
      chk($sformatf("v%0d_ill", k), 64'(ctrl.illegal), 64'(tbl[k].ill_m));
      chk($sformatf("v%0d_md", k), 64'(ctrl.muldiv_en), 64'(tbl[k].md_m));
      chk($sformatf("v%0d_mdop", k), 64'(ctrl.muldiv_op), 64'(tbl[k].mdop));
      chk($sformatf("v%0d_lr_m0", k), 64'(ctrl0.load_regfile), 64'(tbl[k].lr_0));
      chk($sformatf("v%0d_ill_m0", k), 64'(ctrl0.illegal), 64'(tbl[k].ill_0));
    end
    cycle(0, '0, '0, 1, 0);

    // Stall with three back-to-back instructions, then drain in order
    cycle(1, 32'h00500093, 32'h0, 0, 0);
    cycle(1, 32'h00600113, 32'h4, 0, 0);
    #1 chk("seq_in_ready_two", 64'(in_ready), 64'd0);
    chk("seq_head_0", 64'(out_pc), 64'h0);
    cycle(1, 32'h00700193, 32'h8, 0, 0);
    #1 chk("seq_stall_pc", 64'(out_pc), 64'h0);
    chk("seq_stall_imm", 64'(imm), 64'd5);
    cycle(1, 32'h00700193, 32'h8, 1, 0);
    #1 chk("seq_head_4", 64'(out_pc), 64'h4);
    chk("seq_ready_again", 64'(in_ready), 64'd1);
    cycle(1, 32'h00700193, 32'h8, 1, 0);
    #1 chk("seq_head_8", 64'(out_pc), 64'h8);
    chk("seq_head_8_imm", 64'(imm), 64'd7);
    cycle(0, '0, '0, 1, 0);
    #1 chk("seq_drained", 64'(out_valid), 64'd0);

    // Flush from TWO with a simultaneous offer
    cycle(1, 32'h00100093, 32'h10, 0, 0);
    cycle(1, 32'h00200093, 32'h14, 0, 0);
    cycle(1, 32'h00300093, 32'h18, 0, 1);
    #1 chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    cycle(0, '0, '0, 1, 0);
    cycle(1, 32'h00400093, 32'h20, 1, 0);
    #1 chk("post_flush_pc", 64'(out_pc), 64'h20);
    cycle(1, 32'h00500093, 32'h24, 0, 1);
    #1 chk("flush_one_valid", 64'(out_valid), 64'd0);

    // Reset while holding one, then two entries
    cycle(1, 32'h00100013, 32'h30, 0, 0);
    #1 chk("x0_no_write", 64'(ctrl.load_regfile), 64'd0);
    do_reset();
    cycle(1, 32'h00500093, 32'h40, 1, 0);
    #1 chk("rst_first_pc", 64'(out_pc), 64'h40);
    chk("rst_first_valid", 64'(out_valid), 64'd1);
    cycle(1, 32'h00500093, 32'h44, 0, 0);
    do_reset();
    cycle(0, '0, '0, 1, 0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle($urandom_range(0, 3) != 0, rnd_instr(), $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0);
    end
    cycle(0, '0, '0, 1, 0);
    cycle(0, '0, '0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
